// File: rtl/float_mul.sv
// Multi-cycle IEEE-754 binary32 multiplier with start/ready handshake.
// Define FLOAT_MUL_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module float_mul (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] float_in_1,
   input  logic [31:0] float_in_2,
   output logic [31:0] float_out,
   output logic        ready
);

   typedef enum logic [2:0] {StIdle, StUnpack, StMult, StNorm, StDone} state_e;

   state_e             state_q, state_d;
   logic [31:0]        a_q, b_q;
   logic               sign_q;
   logic signed [9:0]  exp_q;
   logic [23:0]        ma_q, mb_q;
   logic               nan_q, inf_q, zero_q;
   logic [47:0]        prod_q;
   logic [31:0]        res_q;

   logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   logic signed [9:0]  exp_sum;
   logic               shift, round_up;
   logic [22:0]        frac, frac_fin;
   logic [24:0]        mant_rnd;
   logic signed [9:0]  exp_norm, exp_fin;
   logic [31:0]        res_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (start) state_d = StUnpack;
         StUnpack: state_d = StMult;
         StMult:   state_d = StNorm;
         StNorm:   state_d = StDone;
         default:  state_d = StIdle;
      endcase
   end

   // Operand classification; denormals count as zero.
   always_comb begin
      a_zero  = (a_q[30:23] == 8'd0);
      b_zero  = (b_q[30:23] == 8'd0);
      a_inf   = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
      b_inf   = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
      a_nan   = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
      b_nan   = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
      exp_sum = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'sd127;
   end

   assign shift = prod_q[47];
   assign frac  = shift ? prod_q[46:24] : prod_q[45:23];

`ifdef FLOAT_MUL_RNE_EN
   logic guard, sticky;
   assign guard    = shift ? prod_q[23] : prod_q[22];
   assign sticky   = shift ? |prod_q[22:0] : |prod_q[21:0];
   assign round_up = guard & (sticky | frac[0]);
`else
   logic unused_lsbs;
   assign unused_lsbs = ^prod_q[22:0];
   assign round_up    = 1'b0;
`endif

   always_comb begin
      exp_norm = exp_q + $signed({9'd0, shift});
      mant_rnd = {2'b01, frac} + {24'd0, round_up};
      // Rounding carry-out means the mantissa became 10.000..., so renormalize.
      exp_fin  = exp_norm + $signed({9'd0, mant_rnd[24]});
      frac_fin = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
      if (nan_q)                    res_d = 32'h7FC00000;
      else if (inf_q)               res_d = {sign_q, 8'hFF, 23'd0};
      else if (zero_q)              res_d = {sign_q, 31'd0};
      else if (exp_fin >= 10'sd255) res_d = {sign_q, 8'hFF, 23'd0};
      else if (exp_fin <= 10'sd0)   res_d = {sign_q, 31'd0};
      else                          res_d = {sign_q, exp_fin[7:0], frac_fin};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         ma_q      <= '0;
         mb_q      <= '0;
         nan_q     <= 1'b0;
         inf_q     <= 1'b0;
         zero_q    <= 1'b0;
         prod_q    <= '0;
         res_q     <= '0;
         float_out <= '0;
         ready     <= 1'b0;
      end else begin
         state_q <= state_d;
         ready   <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  a_q <= float_in_1;
                  b_q <= float_in_2;
               end
            end
            StUnpack: begin
               sign_q <= a_q[31] ^ b_q[31];
               exp_q  <= exp_sum;
               ma_q   <= {1'b1, a_q[22:0]};
               mb_q   <= {1'b1, b_q[22:0]};
               nan_q  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
               inf_q  <= a_inf | b_inf;
               zero_q <= a_zero | b_zero;
            end
            StMult: prod_q <= ma_q * mb_q;
            StNorm: res_q  <= res_d;
            default: begin
               float_out <= res_q;
               ready     <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_float_mul.sv
// Self-checking bench for float_mul: directed cases, random operands vs an arithmetic model,
// held-start throughput and reset abort.
module tb_float_mul;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] float_in_1, float_in_2, float_out;
   logic        ready;
   int          n_total = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   float_mul dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .float_in_1 (float_in_1),
      .float_in_2 (float_in_2),
      .float_out  (float_out),
      .ready      (ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Exact significand product, then scaled to 24 bits with the remainder deciding rounding.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      int ea = int'(a[30:23]);
      int eb = int'(b[30:23]);
      logic sgn = a[31] ^ b[31];
      bit a_zero = (ea == 0);
      bit b_zero = (eb == 0);
      bit a_inf = (ea == 255) && (a[22:0] == 0);
      bit b_inf = (eb == 255) && (b[22:0] == 0);
      bit a_nan = (ea == 255) && (a[22:0] != 0);
      bit b_nan = (eb == 255) && (b[22:0] != 0);
      longint unsigned p, q, r, half;
      int k, e;
      logic [63:0] qv;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
      if (a_inf || b_inf) return {sgn, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {sgn, 31'd0};
      p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      k = (p >= (64'd1 << 47)) ? 24 : 23;
      q = p >> k;
      r = p - (q << k);
      half = 64'd1 << (k - 1);
`ifdef FLOAT_MUL_RNE_EN
      if (r > half || (r == half && q[0])) q = q + 1;
`else
      if (r > half) q = q;
`endif
      e = ea + eb - 127 + (k - 23);
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e++;
      end
      if (e >= 255) return {sgn, 8'hFF, 23'd0};
      if (e <= 0) return {sgn, 31'd0};
      qv = q;
      return {sgn, 8'(e), qv[22:0]};
   endfunction

   // Nearest binary32 to a positive normal real.
   function automatic logic [31:0] real_to_f32(input real r);
      int e = 127;
      real m = r;
      int f;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      f = $rtoi((m - 1.0) * 8388608.0 + 0.5);
      if (f == 8388608) begin f = 0; e++; end
      return {1'b0, 8'(e), 23'(f)};
   endfunction

`ifdef FLOAT_MUL_RNE_EN
   function automatic real f32_val(input logic [31:0] x);
      real v = 1.0 + $itor(int'(x[22:0])) / 8388608.0;
      int e = int'(x[30:23]) - 127;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return v;
   endfunction
`endif

   function automatic logic [31:0] rand_op();
      logic [31:0] v = $urandom;
      case ($urandom_range(0, 9))
         0: v[30:23] = 8'd0;
         1: v[30:23] = 8'hFF;
         2: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
         3: v[30:23] = 8'($urandom_range(192, 254));
         4: v[30:23] = 8'($urandom_range(1, 63));
         default: v[30:23] = 8'($urandom_range(100, 154));
      endcase
      return v;
   endfunction

   // One launch; operands are scrambled right after acceptance and must be ignored.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input string tag);
      int lat = 0;
      @(negedge clk);
      float_in_1 = a;
      float_in_2 = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      float_in_1 = $urandom;
      float_in_2 = $urandom;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!ready && lat < 20);
      check({tag, "_lat"}, lat, 4);
      check(tag, float_out, exp);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, {31'd0, ready}, 32'd0);
      check({tag, "_hold"}, float_out, exp);
   endtask

   initial begin
      logic [31:0] a, b, expv, tie_exp;
      int pulses[$];
      bit seen;

      rst = 1'b1;
      start = 1'b0;
      float_in_1 = '0;
      float_in_2 = '0;
      @(posedge clk);
      #1;
      check("rst_out", float_out, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(32'h3FC00000, 32'h40000000, 32'h40400000, "mul_1p5x2");
      do_op(32'hC0000000, 32'h3F000000, 32'hBF800000, "mul_neg");
      do_op(32'h00000000, 32'h40A00000, 32'h00000000, "mul_zero");
      do_op(32'h80000000, 32'h3F800000, 32'h80000000, "mul_negzero");
`ifdef FLOAT_MUL_RNE_EN
      tie_exp = 32'h3FC00002;
`else
      tie_exp = 32'h3FC00001;
`endif
      do_op(32'h3F800001, 32'h3FC00000, tie_exp, "tie");
      do_op(32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow");
      do_op(32'h00800000, 32'h00800000, 32'h00000000, "underflow");
      do_op(32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero");
      do_op(32'h7FC00000, 32'h3F800000, 32'h7FC00000, "nan_in");
      do_op(32'hFF800000, 32'h40000000, 32'hFF800000, "neg_inf");

      for (int i = 0; i < 40; i++) begin
         a = rand_op();
         b = rand_op();
         do_op(a, b, ref_mul(a, b), $sformatf("rand%0d_%08h_%08h", i, a, b));
      end

      // start held high: accepted at edges 0, 5, 10 -> ready after edges 4, 9, 14
      a = real_to_f32(10231.9382);
      b = real_to_f32(1334.92124);
      expv = ref_mul(a, b);
      @(negedge clk);
      float_in_1 = a;
      float_in_2 = b;
      start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (i == 10) start = 1'b0;
         if (ready) begin
            pulses.push_back(i);
            check("held_val", float_out, expv);
`ifdef FLOAT_MUL_RNE_EN
            check("held_nearest", float_out, real_to_f32(f32_val(a) * f32_val(b)));
`endif
         end
      end
      check("held_cnt", pulses.size(), 3);
      foreach (pulses[k]) check($sformatf("held_at%0d", k), pulses[k], 4 + 5 * k);

      // Reset while in MULT: no ready, output cleared
      @(negedge clk);
      float_in_1 = 32'h40400000;
      float_in_2 = 32'h40400000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_out", float_out, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (ready) seen = 1'b1;
      end
      check("abort_noready", {31'd0, seen}, 32'd0);
      check("abort_out_late", float_out, 32'd0);
      do_op(32'h40400000, 32'h40400000, 32'h41100000, "after_abort");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
